morse_char_buffer: RTL and testbench
====================================

Name: morse_char_buffer

Overview:
Holds the last 8 decoded Morse characters and converts each one to a 7-segment pattern. It produces the 64-bit packed pattern word consumed by the 8-digit display scanner. It sits between the Morse symbol decoder, which emits one character code per completed letter, and the scanner. It also handles user backspace and clear, a blinking ready cursor, and a sticky overflow flag.

Parameters:
BLINK_CYCLES, 500, clk_fast cycles per cursor half-period; must be ≥2.
SEG_ACTIVE_LOW, 0, 1 inverts every output pattern bit (common-anode boards).

Ports:
clk_fast  in  1  block clock, same clock as the scanner's fast scan clock
rst  in  1  reset
char_valid  in  1  one-cycle strobe; char_code is valid
char_code  in  6  0-25 = A-Z, 26-35 = 0-9, 62 = ERR, 63 = BLANK; 36-61 are treated as ERR
bs  in  1  one-cycle backspace strobe
clr  in  1  one-cycle clear strobe
seg_data  out  64  byte i = pattern for digit slot i; slot 0 = rightmost/newest
count  out  4  number of characters held, 0..8
ovf  out  1  sticky: a character has scrolled out since the last clear

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk_fast. On reset:
  - all 8 slots = BLANK, count=0, ovf=0, blink counter=0, blink phase=0
  - seg_data = all-blank pattern (64'h0, or all-ones if SEG_ACTIVE_LOW=1)
- Strobe priority within a cycle: clr > char_valid > bs. Lower-priority strobes in the same cycle are ignored.
- clr:
  - all slots BLANK, count=0, ovf=0
  - blink counter and phase restart at 0
- char_valid (push):
  - slot[i] ← slot[i-1] for i=7..1; slot[0] ← char_code
  - if count<8, count+1
  - if count==8, the old slot[7] is dropped, count stays 8 and ovf←1
  - BLANK (63) pushes like any other code
- bs:
  - if count>0: slot[i] ← slot[i+1] for i=0..6; slot[7] ← BLANK; count−1
  - if count==0: no change
  - ovf is not altered
- Cursor:
  - free-running counter 0..BLINK_CYCLES-1; phase toggles on wrap
  - when count<8 and phase=1, the dp bit of slot 0 is lit
  - the cursor is never shown when count==8
- Overflow marker: while ovf=1, the dp bit of slot 7 is lit.
- Segment bit order per byte is {dp,g,f,e,d,c,b,a}, 1=lit before polarity. Patterns:
  - A=8'h77, E=8'h79, 1=8'h06, 0=8'h3F
  - ERR '-'=8'h40, BLANK=8'h00
  - remaining letters use the standard 7-seg approximations from the package table
- Latency:
  - slots, count and ovf update on the edge where the strobe is sampled
  - seg_data is registered, so it reflects the new slots 1 cycle later
  - when the blink phase toggles, the dp change appears 1 cycle later
- Final output: seg_data = pattern, XORed with all-ones when SEG_ACTIVE_LOW=1.
- Reset mid-operation: everything returns immediately to reset values; no strobe captured in that cycle survives.

Decomposition:
- Package morse_disp_pkg holds:
  - code constants CODE_ERR=6'd62, CODE_BLANK=6'd63, CODE_DIGIT_BASE=6'd26
  - segment bit index constants SEG_DP=7 … SEG_A=0
  - the 64-entry pattern table as a function
- One sub-module, seg_char_rom: combinational code→pattern lookup, instantiated 8 times.

Test Plan:
1. Reset, then push A,E,'1' (codes 0,4,27) -> 3 cycles after the last push, seg_data[23:0]=24'h77_79_06, upper bytes 0, count=3, ovf=0.
2. Push 9 characters (codes 0..8) -> count=8, ovf=1, slot 7 holds code 1 (B), byte 7 has bit 63=1; cursor dp never lit over 4·BLINK_CYCLES.
3. From count=3, strobe bs -> count=2, seg_data[15:0]=16'h77_79; bs at count=0 -> no change.
4. Assert clr, char_valid and bs in the same cycle with count=5, ovf=1 -> count=0, ovf=0, seg_data all zero except the cursor dp.
5. Push code 40 -> byte 0 = 8'h40; with SEG_ACTIVE_LOW=1 the same push -> byte 0 = 8'hBF and blank bytes = 8'hFF.
6. count=1, BLINK_CYCLES=4, no strobes -> bit 7 of seg_data toggles every 4 cycles starting 5 cycles after reset release; rst pulsed mid-sequence -> immediate all-blank output, count=0.

Source files
------------

// File: rtl/morse_char_buffer_pkg.sv
// Shared constants, types and the character-to-segment table
// for the Morse character display buffer.
package morse_disp_pkg;

    typedef logic [5:0] char_code_t;
    typedef logic [7:0] seg_pat_t;

    localparam char_code_t CODE_ERR        = 6'd62;
    localparam char_code_t CODE_BLANK      = 6'd63;
    localparam char_code_t CODE_DIGIT_BASE = 6'd26;

    localparam int SEG_DP = 7;
    localparam int SEG_G  = 6;
    localparam int SEG_F  = 5;
    localparam int SEG_E  = 4;
    localparam int SEG_D  = 3;
    localparam int SEG_C  = 2;
    localparam int SEG_B  = 1;
    localparam int SEG_A  = 0;

    // Bit order {dp,g,f,e,d,c,b,a}, 1 = lit.
    // Codes 36..62 fall to the default dash.
    function automatic seg_pat_t seg_pattern(input char_code_t code);
        seg_pat_t p;
        case (code)
            6'd0:  p = 8'h77;
            6'd1:  p = 8'h7C;
            6'd2:  p = 8'h39;
            6'd3:  p = 8'h5E;
            6'd4:  p = 8'h79;
            6'd5:  p = 8'h71;
            6'd6:  p = 8'h3D;
            6'd7:  p = 8'h76;
            6'd8:  p = 8'h30;
            6'd9:  p = 8'h1E;
            6'd10: p = 8'h75;
            6'd11: p = 8'h38;
            6'd12: p = 8'h37;
            6'd13: p = 8'h54;
            6'd14: p = 8'h5C;
            6'd15: p = 8'h73;
            6'd16: p = 8'h67;
            6'd17: p = 8'h50;
            6'd18: p = 8'h6D;
            6'd19: p = 8'h78;
            6'd20: p = 8'h3E;
            6'd21: p = 8'h1C;
            6'd22: p = 8'h2A;
            6'd23: p = 8'h64;
            6'd24: p = 8'h6E;
            6'd25: p = 8'h5B;
            6'd26: p = 8'h3F;
            6'd27: p = 8'h06;
            6'd28: p = 8'h5B;
            6'd29: p = 8'h4F;
            6'd30: p = 8'h66;
            6'd31: p = 8'h6D;
            6'd32: p = 8'h7D;
            6'd33: p = 8'h07;
            6'd34: p = 8'h7F;
            6'd35: p = 8'h6F;
            CODE_BLANK: p = 8'h00;
            default: p = 8'h40;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/morse_char_buffer_if.sv
// Handshake bundle between decoder/user controls and the buffer.
// master: strobe/code source; slave: the buffer (drives display outputs).
interface morse_char_buffer_if;
    logic        char_valid;
    logic [5:0]  char_code;
    logic        bs;
    logic        clr;
    logic [63:0] seg_data;
    logic [3:0]  count;
    logic        ovf;

    modport master (
        output char_valid, char_code, bs, clr,
        input  seg_data, count, ovf
    );

    modport slave (
        input  char_valid, char_code, bs, clr,
        output seg_data, count, ovf
    );
endinterface

// File: rtl/morse_char_buffer_seg_char_rom.sv
// Combinational character code to 7-segment pattern lookup.
// Ports: code (6b char code) in, pattern (8b {dp..a}) out.
module seg_char_rom
    import morse_disp_pkg::*;
(
    input  char_code_t code,
    output seg_pat_t   pattern
);
    assign pattern = seg_pattern(code);
endmodule

// File: rtl/morse_char_buffer.sv
// 8-slot scrolling Morse character buffer with 7-seg output.
// Ports: clk_fast, rst (async high), bus (slave: strobes in, seg_data/count/ovf out).
module morse_char_buffer
    import morse_disp_pkg::*;
#(
    parameter int BLINK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input logic              clk_fast,
    input logic              rst,
    morse_char_buffer_if.slave bus
);
    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    char_code_t    slot_q [8];
    logic [3:0]    count_q;
    logic          ovf_q;
    logic [BW-1:0] blink_cnt;
    logic          phase_q;
    logic [63:0]   seg_q;
    logic [63:0]   seg_next;
    seg_pat_t      raw [8];

    for (genvar g = 0; g < 8; g++) begin : g_rom
        seg_char_rom u_rom (
            .code    (slot_q[g]),
            .pattern (raw[g])
        );
    end

    // Cursor on the newest slot, overflow marker on the oldest.
    always_comb begin
        seg_next = '0;
        for (int i = 0; i < 8; i++) begin
            seg_next[8*i +: 8] = raw[i];
        end
        if (count_q < 4'd8 && phase_q) begin
            seg_next[SEG_DP] = 1'b1;
        end
        if (ovf_q) begin
            seg_next[56 + SEG_DP] = 1'b1;
        end
        if (SEG_ACTIVE_LOW) begin
            seg_next = ~seg_next;
        end
    end

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= CODE_BLANK;
            end
            count_q   <= '0;
            ovf_q     <= 1'b0;
            blink_cnt <= '0;
            phase_q   <= 1'b0;
            seg_q     <= {64{SEG_ACTIVE_LOW}};
        end else begin
            seg_q <= seg_next;
            if (bus.clr) begin
                for (int i = 0; i < 8; i++) begin
                    slot_q[i] <= CODE_BLANK;
                end
                count_q   <= '0;
                ovf_q     <= 1'b0;
                blink_cnt <= '0;
                phase_q   <= 1'b0;
            end else begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase_q   <= ~phase_q;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
                if (bus.char_valid) begin
                    for (int i = 7; i > 0; i--) begin
                        slot_q[i] <= slot_q[i-1];
                    end
                    slot_q[0] <= bus.char_code;
                    if (count_q == 4'd8) begin
                        ovf_q <= 1'b1;
                    end else begin
                        count_q <= count_q + 4'd1;
                    end
                end else if (bus.bs && count_q != 4'd0) begin
                    for (int i = 0; i < 7; i++) begin
                        slot_q[i] <= slot_q[i+1];
                    end
                    slot_q[7] <= CODE_BLANK;
                    count_q   <= count_q - 4'd1;
                end
            end
        end
    end

    assign bus.seg_data = seg_q;
    assign bus.count    = count_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_morse_char_buffer.sv
// Randomized self-checking bench for morse_char_buffer:
// queue-based display model plus directed literal checks.
module tb_morse_char_buffer;
    localparam int BLINK = 4;

    logic clk_fast = 1'b0;
    logic rst = 1'b1;
    always #5 clk_fast = ~clk_fast;

    morse_char_buffer_if vi ();
    morse_char_buffer_if vi2 ();

    morse_char_buffer #(.BLINK_CYCLES(BLINK), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk_fast (clk_fast),
        .rst      (rst),
        .bus      (vi)
    );

    morse_char_buffer #(.BLINK_CYCLES(BLINK), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clk_fast (clk_fast),
        .rst      (rst),
        .bus      (vi2)
    );

    logic [7:0] letters [26] = '{
        8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76,
        8'h30, 8'h1E, 8'h75, 8'h38, 8'h37, 8'h54, 8'h5C, 8'h73,
        8'h67, 8'h50, 8'h6D, 8'h78, 8'h3E, 8'h1C, 8'h2A, 8'h64,
        8'h6E, 8'h5B};
    logic [7:0] digits [10] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // Model: newest-first queue, sticky flag, cycles since reset/clear.
    int mq [$];
    bit movf = 1'b0;
    int mt = 0;
    logic [63:0] exp0 = '0;
    logic [63:0] exp1 = '1;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    function automatic logic [7:0] pat(input int c);
        if (c < 26) return letters[c];
        if (c < 36) return digits[c-26];
        if (c == 63) return 8'h00;
        return 8'h40;
    endfunction

    function automatic logic [63:0] render(input bit low);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < mq.size(); i++) s[8*i +: 8] = pat(mq[i]);
        if (mq.size() < 8 && ((mt / BLINK) % 2) == 1) s[7] = 1'b1;
        if (movf) s[63] = 1'b1;
        if (low) s = ~s;
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_fast or posedge rst);
            exp0 = render(1'b0);
            exp1 = render(1'b1);
            if (rst) begin
                mq.delete();
                movf = 1'b0;
                mt = 0;
                exp0 = render(1'b0);
                exp1 = render(1'b1);
            end else if (vi.clr) begin
                mq.delete();
                movf = 1'b0;
                mt = 0;
            end else begin
                mt++;
                if (vi.char_valid) begin
                    mq.push_front(int'(vi.char_code));
                    if (mq.size() > 8) begin
                        void'(mq.pop_back());
                        movf = 1'b1;
                    end
                end else if (vi.bs && mq.size() > 0) begin
                    void'(mq.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_fast);
            if (check_en) begin
                check("seg_data", vi.seg_data, exp0);
                check("seg_data_al", vi2.seg_data, exp1);
                check("count", 64'(vi.count), 64'(mq.size()));
                check("ovf", 64'(vi.ovf), 64'(movf));
            end
        end
    end

    task automatic drive(input logic v, input logic [5:0] c,
                         input logic b, input logic cl);
        vi.char_valid = v;  vi2.char_valid = v;
        vi.char_code  = c;  vi2.char_code  = c;
        vi.bs         = b;  vi2.bs         = b;
        vi.clr        = cl; vi2.clr        = cl;
    endtask

    task automatic tick(input logic v, input logic [5:0] c,
                        input logic b, input logic cl);
        drive(v, c, b, cl);
        @(posedge clk_fast);
        #1;
        drive(1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_fast);
        #1;
    endtask

    initial begin
        logic [63:0] s;
        drive(1'b0, 6'd0, 1'b0, 1'b0);
        @(posedge clk_fast);
        #1;
        check_en = 1'b1;
        @(negedge clk_fast);
        check("rst_seg", vi.seg_data, 64'h0);
        check("rst_seg_al", vi2.seg_data, {64{1'b1}});
        check("rst_count", 64'(vi.count), 64'd0);
        check("rst_ovf", 64'(vi.ovf), 64'd0);
        @(posedge clk_fast);
        #1 rst = 1'b0;

        tick(1'b1, 6'd0, 1'b0, 1'b0);
        tick(1'b1, 6'd4, 1'b0, 1'b0);
        tick(1'b1, 6'd27, 1'b0, 1'b0);
        idle(3);
        @(negedge clk_fast);
        s = vi.seg_data;
        check("t1_low", 64'({s[23:8], s[6:0]}), 64'({16'h7779, 7'h06}));
        check("t1_high", 64'(s[63:24]), 64'd0);
        check("t1_count", 64'(vi.count), 64'd3);
        check("t1_ovf", 64'(vi.ovf), 64'd0);

        tick(1'b0, 6'd0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) tick(1'b1, 6'(i), 1'b0, 1'b0);
        idle(1);
        @(negedge clk_fast);
        s = vi.seg_data;
        check("t2_count", 64'(vi.count), 64'd8);
        check("t2_ovf", 64'(vi.ovf), 64'd1);
        check("t2_slot7", 64'(s[63:56]), 64'h FC);
        for (int k = 0; k < 4 * BLINK; k++) begin
            @(negedge clk_fast);
            check("t2_nocursor", 64'(vi.seg_data[7]), 64'd0);
        end

        tick(1'b0, 6'd0, 1'b0, 1'b1);
        tick(1'b1, 6'd0, 1'b0, 1'b0);
        tick(1'b1, 6'd4, 1'b0, 1'b0);
        tick(1'b1, 6'd27, 1'b0, 1'b0);
        tick(1'b0, 6'd0, 1'b1, 1'b0);
        idle(1);
        @(negedge clk_fast);
        s = vi.seg_data;
        check("t3_count", 64'(vi.count), 64'd2);
        check("t3_bytes", 64'({s[15:8], s[6:0]}), 64'({8'h77, 7'h79}));
        tick(1'b0, 6'd0, 1'b1, 1'b0);
        tick(1'b0, 6'd0, 1'b1, 1'b0);
        tick(1'b0, 6'd0, 1'b1, 1'b0);
        idle(1);
        @(negedge clk_fast);
        check("t3_empty", 64'(vi.count), 64'd0);

        for (int i = 0; i < 10; i++) tick(1'b1, 6'(i + 10), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 6'd0, 1'b1, 1'b0);
        @(negedge clk_fast);
        check("t4_pre_count", 64'(vi.count), 64'd5);
        check("t4_pre_ovf", 64'(vi.ovf), 64'd1);
        tick(1'b1, 6'd7, 1'b1, 1'b1);
        idle(1);
        @(negedge clk_fast);
        s = vi.seg_data;
        check("t4_count", 64'(vi.count), 64'd0);
        check("t4_ovf", 64'(vi.ovf), 64'd0);
        check("t4_seg", {s[63:8], 1'b0, s[6:0]}, 64'd0);

        tick(1'b1, 6'd40, 1'b0, 1'b0);
        idle(1);
        @(negedge clk_fast);
        check("t5_err", 64'(vi.seg_data[6:0]), 64'h40);
        check("t5_err_al", 64'(vi2.seg_data[6:0]), 64'h3F);
        check("t5_blank_al", 64'(vi2.seg_data[63:8]), {8'h00, {56{1'b1}}});

        @(posedge clk_fast);
        #1 rst = 1'b1;
        @(posedge clk_fast);
        #1 rst = 1'b0;
        tick(1'b1, 6'd5, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_fast);
            check("t6_blink", 64'(vi.seg_data[7]), 64'(((k - 1) / 4) % 2));
        end
        @(posedge clk_fast);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_seg", vi.seg_data, 64'h0);
        check("t6_rst_count", 64'(vi.count), 64'd0);
        @(posedge clk_fast);
        #1 rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                @(posedge clk_fast);
                #1 rst = 1'b0;
            end else begin
                logic v, b, cl;
                logic [5:0] c;
                cl = ($urandom_range(0, 99) < 2);
                v  = ($urandom_range(0, 99) < 45);
                b  = ($urandom_range(0, 99) < 30);
                if ($urandom_range(0, 9) < 7) c = 6'($urandom_range(0, 35));
                else c = 6'($urandom_range(0, 63));
                tick(v, c, b, cl);
            end
        end
        idle(2);
        @(negedge clk_fast);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
